// File: rtl/avalon_lock_arbiter_pkg.sv
// Shared interconnect types for the two-master Avalon lock arbiter:
// arbiter state encoding and the Avalon request bundle used on every port.
package avalon_lock_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    LOCKED = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic        read;
    logic        write;
    logic        lock;
  } avl_req_t;

  function automatic logic is_request(input avl_req_t r);
    return r.read | r.write;
  endfunction

endpackage

// File: rtl/avalon_port_mux.sv
// 2:1 request selection toward the slave plus waitrequest steering back to
// the masters; purely combinational.
module avalon_port_mux
  import avalon_lock_arbiter_pkg::*;
(
  input  avl_req_t s0,
  input  avl_req_t s1,
  input  logic     sel_valid,
  input  logic     sel,
  input  logic     m_waitrequest,
  output avl_req_t m,
  output logic     s0_waitrequest,
  output logic     s1_waitrequest
);

  // Without a selection the slave sees no strobes and both masters stall.
  always_comb begin
    m              = '0;
    s0_waitrequest = 1'b1;
    s1_waitrequest = 1'b1;
    if (sel_valid) begin
      if (sel) begin
        m              = s1;
        s1_waitrequest = m_waitrequest;
      end else begin
        m              = s0;
        s0_waitrequest = m_waitrequest;
      end
    end
  end

endmodule

// File: rtl/avalon_lock_arbiter.sv
// Round-robin two-master Avalon arbiter with zero added latency, lock
// support for atomic sequences and a watchdog on idle locks.
module avalon_lock_arbiter
  import avalon_lock_arbiter_pkg::*;
#(
  parameter int LOCK_MAX = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s0_addr,
  input  logic [3:0]  s0_byteenable,
  input  logic [31:0] s0_writedata,
  input  logic        s0_read,
  input  logic        s0_write,
  input  logic        s0_lock,
  input  logic [31:0] s1_addr,
  input  logic [3:0]  s1_byteenable,
  input  logic [31:0] s1_writedata,
  input  logic        s1_read,
  input  logic        s1_write,
  input  logic        s1_lock,
  output logic        s0_waitrequest,
  output logic        s1_waitrequest,
  output logic [31:0] s0_readdata,
  output logic [31:0] s1_readdata,
  output logic [31:0] m_addr,
  output logic [3:0]  m_byteenable,
  output logic [31:0] m_writedata,
  output logic        m_read,
  output logic        m_write,
  output logic        m_lock,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  output logic [1:0]  grant,
  output logic        lock_timeout,
  output arb_state_t  state
);

  localparam int CW = $clog2(LOCK_MAX);
  localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_MAX - 1);

  // Handshake: a master's request (read|write with its fields) is accepted in
  // the cycle its waitrequest is low; while waitrequest is high it must hold
  // every request field, lock included, stable.

  avl_req_t   s0_req, s1_req, m_req;
  arb_state_t state_n;
  logic       owner, owner_n;
  logic       last, last_n;
  logic       lock_timeout_n;
  logic [CW-1:0] idle_cnt, idle_cnt_n;
  logic       sel_valid, sel;
  logic       req0, req1, own_req, own_lock, oth_req;

  assign s0_req = '{addr: s0_addr, byteenable: s0_byteenable, writedata: s0_writedata,
                    read: s0_read, write: s0_write, lock: s0_lock};
  assign s1_req = '{addr: s1_addr, byteenable: s1_byteenable, writedata: s1_writedata,
                    read: s1_read, write: s1_write, lock: s1_lock};

  assign req0     = is_request(s0_req);
  assign req1     = is_request(s1_req);
  assign own_req  = owner ? req1 : req0;
  assign own_lock = owner ? s1_lock : s0_lock;
  assign oth_req  = owner ? req0 : req1;

  always_comb begin
    state_n        = state;
    owner_n        = owner;
    last_n         = last;
    idle_cnt_n     = idle_cnt;
    lock_timeout_n = lock_timeout;
    sel_valid      = 1'b0;
    sel            = owner;
    case (state)
      IDLE: begin
        if (req0 | req1) begin
          sel_valid = 1'b1;
          sel       = (req0 & req1) ? ~last : req1;
          if (!m_waitrequest) begin
            last_n = sel;
            if (sel ? s1_lock : s0_lock) begin
              state_n = LOCKED;
              owner_n = sel;
            end
          end else begin
            state_n = BUSY;
            owner_n = sel;
          end
        end
      end
      BUSY: begin
        sel_valid = 1'b1;
        if (!m_waitrequest) begin
          last_n  = owner;
          state_n = own_lock ? LOCKED : IDLE;
        end
      end
      LOCKED: begin
        sel_valid = 1'b1;
        if (own_req) begin
          idle_cnt_n = '0;
          if (!m_waitrequest) begin
            last_n = owner;
            if (!own_lock) state_n = IDLE;
          end
        end else if (!own_lock) begin
          state_n    = IDLE;
          idle_cnt_n = '0;
        end else if (idle_cnt == CNT_MAX && oth_req) begin
          // last already names the owner, so the starved port wins next.
          state_n        = IDLE;
          idle_cnt_n     = '0;
          lock_timeout_n = 1'b1;
        end else if (idle_cnt != CNT_MAX) begin
          idle_cnt_n = idle_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (rst) sel_valid = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      owner        <= 1'b0;
      last         <= 1'b1;
      idle_cnt     <= '0;
      lock_timeout <= 1'b0;
    end else begin
      state        <= state_n;
      owner        <= owner_n;
      last         <= last_n;
      idle_cnt     <= idle_cnt_n;
      lock_timeout <= lock_timeout_n;
    end
  end

  avalon_port_mux u_mux (
    .s0             (s0_req),
    .s1             (s1_req),
    .sel_valid      (sel_valid),
    .sel            (sel),
    .m_waitrequest  (m_waitrequest),
    .m              (m_req),
    .s0_waitrequest (s0_waitrequest),
    .s1_waitrequest (s1_waitrequest)
  );

  assign m_addr       = m_req.addr;
  assign m_byteenable = m_req.byteenable;
  assign m_writedata  = m_req.writedata;
  assign m_read       = m_req.read;
  assign m_write      = m_req.write;
  assign m_lock       = m_req.lock;

  assign s0_readdata = m_readdata;
  assign s1_readdata = m_readdata;

  assign grant = (state == IDLE) ? 2'b00 : (owner ? 2'b10 : 2'b01);

endmodule

// File: tb/tb_avalon_lock_arbiter.sv
// Bench for avalon_lock_arbiter: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_avalon_lock_arbiter;
  import avalon_lock_arbiter_pkg::*;

  localparam int LM = 8;

  logic        clk, rst;
  logic [31:0] s0_addr, s1_addr, s0_writedata, s1_writedata;
  logic [3:0]  s0_byteenable, s1_byteenable;
  logic        s0_read, s0_write, s0_lock, s1_read, s1_write, s1_lock;
  logic        s0_waitrequest, s1_waitrequest;
  logic [31:0] s0_readdata, s1_readdata;
  logic [31:0] m_addr, m_writedata, m_readdata;
  logic [3:0]  m_byteenable;
  logic        m_read, m_write, m_lock, m_waitrequest;
  logic [1:0]  grant;
  logic        lock_timeout;
  arb_state_t  state;

  int n_checks = 0;
  int n_err    = 0;

  // model: owner (-1 = none), whether owner holds a lock, last completed owner
  int mo_owner, mo_last, mo_idle;
  bit mo_locked, mo_to;
  bit done_q[2];
  bit act[2];

  avalon_lock_arbiter #(.LOCK_MAX(LM)) dut (
    .clk(clk), .rst(rst),
    .s0_addr(s0_addr), .s0_byteenable(s0_byteenable), .s0_writedata(s0_writedata),
    .s0_read(s0_read), .s0_write(s0_write), .s0_lock(s0_lock),
    .s1_addr(s1_addr), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_read(s1_read), .s1_write(s1_write), .s1_lock(s1_lock),
    .s0_waitrequest(s0_waitrequest), .s1_waitrequest(s1_waitrequest),
    .s0_readdata(s0_readdata), .s1_readdata(s1_readdata),
    .m_addr(m_addr), .m_byteenable(m_byteenable), .m_writedata(m_writedata),
    .m_read(m_read), .m_write(m_write), .m_lock(m_lock),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .grant(grant), .lock_timeout(lock_timeout), .state(state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic preq(input int p);
    return (p == 0) ? (s0_read | s0_write) : (s1_read | s1_write);
  endfunction
  function automatic logic plock(input int p);
    return (p == 0) ? s0_lock : s1_lock;
  endfunction

  task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_checks++;
    if (act_v !== exp_v) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act_v, exp_v);
    end
  endtask

  task automatic set_port(input int p, input logic rd, input logic wr, input logic lk,
                          input logic [31:0] a, input logic [31:0] wd);
    if (p == 0) begin
      s0_read = rd; s0_write = wr; s0_lock = lk;
      s0_addr = a; s0_writedata = wd; s0_byteenable = a[3:0];
    end else begin
      s1_read = rd; s1_write = wr; s1_lock = lk;
      s1_addr = a; s1_writedata = wd; s1_byteenable = a[7:4];
    end
  endtask

  task automatic model_reset();
    mo_owner = -1; mo_last = 1; mo_idle = 0; mo_locked = 0; mo_to = 0;
    done_q[0] = 0; done_q[1] = 0;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Compare every output against the model at the negative edge, then
  // advance the model with the inputs that the next posedge will see.
  task automatic check_cycle();
    int sel;
    logic e_rd, e_wr, e_lk, e_w0, e_w1;
    logic [1:0] e_grant;
    logic rq, lk;
    @(negedge clk);
    if (rst) model_reset();
    if (rst) sel = -1;
    else if (mo_owner >= 0) sel = mo_owner;
    else if (preq(0) && preq(1)) sel = 1 - mo_last;
    else if (preq(0)) sel = 0;
    else if (preq(1)) sel = 1;
    else sel = -1;
    e_rd = 0; e_wr = 0; e_lk = 0;
    if (sel == 0) begin e_rd = s0_read; e_wr = s0_write; e_lk = s0_lock; end
    if (sel == 1) begin e_rd = s1_read; e_wr = s1_write; e_lk = s1_lock; end
    e_w0 = (sel == 0) ? m_waitrequest : 1'b1;
    e_w1 = (sel == 1) ? m_waitrequest : 1'b1;
    e_grant = (mo_owner < 0) ? 2'b00 : (mo_owner == 0 ? 2'b01 : 2'b10);
    chk("m_read", 32'(m_read), 32'(e_rd));
    chk("m_write", 32'(m_write), 32'(e_wr));
    chk("m_lock", 32'(m_lock), 32'(e_lk));
    chk("s0_waitrequest", 32'(s0_waitrequest), 32'(e_w0));
    chk("s1_waitrequest", 32'(s1_waitrequest), 32'(e_w1));
    chk("grant", 32'(grant), 32'(e_grant));
    chk("lock_timeout", 32'(lock_timeout), 32'(mo_to));
    chk("s0_readdata", s0_readdata, m_readdata);
    chk("s1_readdata", s1_readdata, m_readdata);
    if (sel == 0) begin
      chk("m_addr", m_addr, s0_addr);
      chk("m_byteenable", 32'(m_byteenable), 32'(s0_byteenable));
      chk("m_writedata", m_writedata, s0_writedata);
    end else if (sel == 1) begin
      chk("m_addr", m_addr, s1_addr);
      chk("m_byteenable", 32'(m_byteenable), 32'(s1_byteenable));
      chk("m_writedata", m_writedata, s1_writedata);
    end
    done_q[0] = preq(0) && !e_w0;
    done_q[1] = preq(1) && !e_w1;
    if (!rst && sel >= 0) begin
      rq = preq(sel);
      lk = plock(sel);
      if (mo_owner < 0) begin
        if (!m_waitrequest) begin
          mo_last = sel;
          if (lk) begin mo_owner = sel; mo_locked = 1; mo_idle = 0; end
        end else begin
          mo_owner = sel; mo_locked = 0;
        end
      end else if (!mo_locked) begin
        if (!m_waitrequest) begin
          mo_last = mo_owner;
          if (lk) begin mo_locked = 1; mo_idle = 0; end
          else mo_owner = -1;
        end
      end else if (rq) begin
        mo_idle = 0;
        if (!m_waitrequest && !lk) mo_owner = -1;
      end else if (!lk) begin
        mo_owner = -1; mo_idle = 0;
      end else if (mo_idle == LM - 1 && preq(1 - sel)) begin
        mo_owner = -1; mo_idle = 0; mo_to = 1;
      end else if (mo_idle < LM - 1) begin
        mo_idle++;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_port(0, 0, 0, 0, 32'h0, 32'h0);
    set_port(1, 0, 0, 0, 32'h0, 32'h0);
    m_waitrequest = 1'b0;
    m_readdata = 32'h0;
    check_cycle();
    adv();
    rst = 1'b0;
  endtask

  task automatic drive_random(input int p, input int reqp);
    logic k;
    if (act[p] && !done_q[p]) return;
    if ($urandom_range(0, 99) < reqp) begin
      act[p] = 1;
      k = 1'($urandom_range(0, 1));
      set_port(p, k, ~k, ($urandom_range(0, 3) == 0), $urandom, $urandom);
    end else begin
      act[p] = 0;
      k = ($urandom_range(0, 9) < 8) ? plock(p) : 1'($urandom_range(0, 1));
      set_port(p, 0, 0, k, $urandom, $urandom);
    end
  endtask

  initial begin
    int reqp;
    model_reset();
    rst = 1'b1;
    set_port(0, 0, 0, 0, 32'h0, 32'h0);
    set_port(1, 0, 0, 0, 32'h0, 32'h0);
    m_waitrequest = 1'b0;
    m_readdata = 32'h0;
    #2;
    // reset values
    check_cycle();
    chk("rst grant", 32'(grant), 32'h0);
    chk("rst s0_wait", 32'(s0_waitrequest), 32'h1);
    chk("rst s1_wait", 32'(s1_waitrequest), 32'h1);
    chk("rst m_read", 32'(m_read), 32'h0);
    chk("rst timeout", 32'(lock_timeout), 32'h0);
    adv();
    rst = 1'b0;

    // single read by port 0, slave stalls one extra cycle
    set_port(0, 1, 0, 0, 32'h100, 32'h0);
    m_waitrequest = 1'b1;
    check_cycle();
    chk("t1 grant idle", 32'(grant), 32'h0);
    chk("t1 m_addr", m_addr, 32'h100);
    chk("t1 s0_wait", 32'(s0_waitrequest), 32'h1);
    adv();
    check_cycle();
    chk("t1 grant busy", 32'(grant), 32'h1);
    adv();
    m_waitrequest = 1'b0;
    m_readdata = 32'hDEADBEEF;
    check_cycle();
    chk("t1 s0_wait done", 32'(s0_waitrequest), 32'h0);
    chk("t1 readdata", s0_readdata, 32'hDEADBEEF);
    adv();
    set_port(0, 0, 0, 0, 32'h0, 32'h0);
    check_cycle();
    chk("t1 grant after", 32'(grant), 32'h0);
    adv();

    // both write every cycle, zero-wait slave: strict alternation from port 0
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_port(0, 0, 1, 0, 32'h1000 + i, 32'hA0 + i);
      set_port(1, 0, 1, 0, 32'h2000 + i, 32'hB0 + i);
      check_cycle();
      chk("t2 winner", (s0_waitrequest == 1'b0) ? 32'h0 : 32'h1, 32'(i % 2));
      adv();
    end

    // locked sequence by port 0 while port 1 requests throughout
    do_reset();
    set_port(0, 1, 0, 1, 32'h300, 32'h0);
    set_port(1, 0, 1, 0, 32'h200, 32'h55);
    check_cycle();
    chk("t3 s0 first", 32'(s0_waitrequest), 32'h0);
    adv();
    set_port(0, 0, 0, 1, 32'h300, 32'h0);
    for (int i = 0; i < 5; i++) begin
      check_cycle();
      chk("t3 s1 stalled", 32'(s1_waitrequest), 32'h1);
      chk("t3 grant locked", 32'(grant), 32'h1);
      adv();
    end
    set_port(0, 0, 1, 1, 32'h300, 32'h77);
    check_cycle();
    chk("t3 locked write", 32'(s0_waitrequest), 32'h0);
    adv();
    set_port(0, 0, 0, 0, 32'h0, 32'h0);
    check_cycle();
    chk("t3 s1 still stalled", 32'(s1_waitrequest), 32'h1);
    adv();
    check_cycle();
    chk("t3 s1 granted", 32'(s1_waitrequest), 32'h0);
    chk("t3 m_addr", m_addr, 32'h200);
    adv();
    set_port(1, 0, 0, 0, 32'h0, 32'h0);

    // idle lock exceeding the watchdog
    do_reset();
    set_port(0, 1, 0, 1, 32'h400, 32'h0);
    set_port(1, 0, 1, 0, 32'h500, 32'h66);
    check_cycle();
    adv();
    set_port(0, 0, 0, 1, 32'h400, 32'h0);
    for (int i = 0; i < LM; i++) begin
      check_cycle();
      chk("t4 s1 stalled", 32'(s1_waitrequest), 32'h1);
      chk("t4 no timeout yet", 32'(lock_timeout), 32'h0);
      adv();
    end
    set_port(0, 1, 0, 0, 32'h404, 32'h0);
    check_cycle();
    chk("t4 timeout", 32'(lock_timeout), 32'h1);
    chk("t4 s1 granted", 32'(s1_waitrequest), 32'h0);
    chk("t4 s0 stalled", 32'(s0_waitrequest), 32'h1);
    adv();

    // asynchronous reset in the middle of a stalled transfer
    do_reset();
    m_waitrequest = 1'b1;
    set_port(0, 0, 1, 0, 32'h600, 32'h11);
    set_port(1, 0, 1, 0, 32'h700, 32'h22);
    check_cycle();
    adv();
    check_cycle();
    chk("t5 busy grant", 32'(grant), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5 rst grant", 32'(grant), 32'h0);
    chk("t5 rst m_write", 32'(m_write), 32'h0);
    chk("t5 rst s0_wait", 32'(s0_waitrequest), 32'h1);
    chk("t5 rst s1_wait", 32'(s1_waitrequest), 32'h1);
    model_reset();
    adv();
    rst = 1'b0;
    m_waitrequest = 1'b0;
    check_cycle();
    chk("t5 tie s0", 32'(s0_waitrequest), 32'h0);
    chk("t5 tie s1", 32'(s1_waitrequest), 32'h1);
    adv();

    // randomized traffic
    do_reset();
    act[0] = 0; act[1] = 0;
    reqp = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 256 == 0) reqp = $urandom_range(5, 70);
      drive_random(0, reqp);
      drive_random(1, reqp);
      m_waitrequest = ($urandom_range(0, 2) == 0);
      m_readdata = $urandom;
      check_cycle();
      adv();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
